coin_input_conditioner: RTL and testbench

- Front-end stage feeding the vending machine FSM.
- Takes raw, bouncy, asynchronous coin-slot sensors (quarter/dime/nickel) and selection buttons (soda/diet), synchronizes and debounces them, and queues coin events.
- Issues clean single-cycle pulses Q/D/N/soda/diet so the FSM sees exactly one pulse per physical event, never two coins in the same cycle.

---
 rtl/coin_input_conditioner.sv | 173 +++++++++++++++++
 tb/tb_coin_input_conditioner.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_input_conditioner.sv
// Coin/selection input conditioner: synchronizes, debounces and queues
// raw vending-machine sensors, issuing clean single-cycle pulses.
//
// Ports:
//   CLK           - clock, all logic on rising edge
//   reset         - synchronous, active-low reset
//   q_raw/d_raw/n_raw      - raw async coin sensors (active-high)
//   soda_raw/diet_raw      - raw async selection buttons (active-high)
//   accept        - downstream ready; coin pulses only issue while high
//   Q/D/N         - one-cycle coin pulses, at most one per cycle
//   soda/diet     - one-cycle selection pulses
//   coin_pending  - any coin queue counter nonzero
//   coin_overflow - sticky flag: a coin event was dropped (cleared by reset)
module coin_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 8,
    parameter int GAP_CYCLES      = 1
) (
    input  logic CLK,
    input  logic reset,
    input  logic q_raw,
    input  logic d_raw,
    input  logic n_raw,
    input  logic soda_raw,
    input  logic diet_raw,
    input  logic accept,
    output logic Q,
    output logic D,
    output logic N,
    output logic soda,
    output logic diet,
    output logic coin_pending,
    output logic coin_overflow
);

    localparam int NCH = 5;
    localparam logic [CNT_W-1:0] DB_LIM = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [3:0] GAP_LD = 4'(GAP_CYCLES);

    // Channel order: 0=quarter 1=dime 2=nickel 3=soda 4=diet
    logic [NCH-1:0] raw;
    logic [NCH-1:0] sync1;
    logic [NCH-1:0] sync2;
    logic [NCH-1:0] deb;
    logic [NCH-1:0] deb_d;
    logic [NCH-1:0] evt;
    logic [CNT_W-1:0] cnt [NCH];

    logic [1:0] q_pend;
    logic [1:0] d_pend;
    logic [1:0] n_pend;
    logic [2:0] q_nx;
    logic [2:0] d_nx;
    logic [2:0] n_nx;
    logic [2:0] grant;
    logic [3:0] gap;

    assign raw = {diet_raw, soda_raw, n_raw, d_raw, q_raw};

    // Two-flop synchronizer for every channel
    always_ff @(posedge CLK) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Debouncer: the counter tracks how long sync has disagreed with deb;
    // once it has counted DEBOUNCE_CYCLES disagreeing cycles and the
    // disagreement persists one more cycle, deb follows sync.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            deb   <= '0;
            deb_d <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            deb_d <= deb;
            for (int i = 0; i < NCH; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DB_LIM) begin
                    deb[i] <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // One-cycle strobe on each debounced rising edge
    assign evt = deb & ~deb_d;

    // Returns {dropped, next_count} for a saturating 0..3 pending counter
    function automatic logic [2:0] pend_next(
        input logic [1:0] p,
        input logic       inc,
        input logic       dec
    );
        logic [2:0] r;
        r = {1'b0, p};
        if (inc && !dec) begin
            if (p == 2'd3) begin
                r = {1'b1, p};
            end else begin
                r = {1'b0, p + 2'd1};
            end
        end else if (!inc && dec) begin
            r = {1'b0, p - 2'd1};
        end
        return r;
    endfunction

    // Arbiter: fixed priority Q > D > N, gated by accept and the gap timer
    always_comb begin
        grant = '0;
        if (accept && gap == 4'd0) begin
            if (q_pend != 2'd0) begin
                grant[0] = 1'b1;
            end else if (d_pend != 2'd0) begin
                grant[1] = 1'b1;
            end else if (n_pend != 2'd0) begin
                grant[2] = 1'b1;
            end
        end
    end

    assign q_nx = pend_next(q_pend, evt[0], grant[0]);
    assign d_nx = pend_next(d_pend, evt[1], grant[1]);
    assign n_nx = pend_next(n_pend, evt[2], grant[2]);

    always_ff @(posedge CLK) begin
        if (!reset) begin
            q_pend        <= '0;
            d_pend        <= '0;
            n_pend        <= '0;
            coin_overflow <= 1'b0;
            gap           <= '0;
            Q             <= 1'b0;
            D             <= 1'b0;
            N             <= 1'b0;
            soda          <= 1'b0;
            diet          <= 1'b0;
        end else begin
            q_pend <= q_nx[1:0];
            d_pend <= d_nx[1:0];
            n_pend <= n_nx[1:0];
            if (q_nx[2] || d_nx[2] || n_nx[2]) begin
                coin_overflow <= 1'b1;
            end
            if (grant != 3'd0) begin
                gap <= GAP_LD;
            end else if (gap != 4'd0) begin
                gap <= gap - 4'd1;
            end
            Q    <= grant[0];
            D    <= grant[1];
            N    <= grant[2];
            // Selections bypass the queue; soda wins a same-cycle tie
            soda <= evt[3];
            diet <= evt[4] & ~evt[3];
        end
    end

    assign coin_pending = (q_pend != 2'd0) || (d_pend != 2'd0) ||
                          (n_pend != 2'd0);

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Self-checking bench for coin_input_conditioner: table-driven events
// plus hand-written corner sequences, with a pulse scoreboard.
module tb_coin_input_conditioner;

    localparam int DB       = 4;
    localparam int GAP      = 1;
    localparam int LAT_COIN = DB + 4;
    localparam int LAT_SEL  = DB + 3;

    logic CLK = 1'b0;
    logic reset = 1'b0;
    logic q_raw = 1'b0;
    logic d_raw = 1'b0;
    logic n_raw = 1'b0;
    logic soda_raw = 1'b0;
    logic diet_raw = 1'b0;
    logic accept = 1'b1;
    logic Q, D, N, soda, diet, coin_pending, coin_overflow;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        int kind;
        int at;
    } exp_t;
    exp_t sb[$];

    // lines/pulses bit order: 0=q 1=d 2=n 3=soda 4=diet
    typedef struct {
        string      name;
        logic [4:0] lines;
        int         hold;
        logic [4:0] pulses;
    } vec_t;
    vec_t vecs[10];

    string kname[5] = '{"Q", "D", "N", "soda", "diet"};

    coin_input_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .CNT_W(8),
        .GAP_CYCLES(GAP)
    ) dut (
        .CLK(CLK),
        .reset(reset),
        .q_raw(q_raw),
        .d_raw(d_raw),
        .n_raw(n_raw),
        .soda_raw(soda_raw),
        .diet_raw(diet_raw),
        .accept(accept),
        .Q(Q),
        .D(D),
        .N(N),
        .soda(soda),
        .diet(diet),
        .coin_pending(coin_pending),
        .coin_overflow(coin_overflow)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic drive(input logic [4:0] v);
        {diet_raw, soda_raw, n_raw, d_raw, q_raw} = v;
    endtask

    task automatic push(input int kind, input int at);
        exp_t e;
        e.kind = kind;
        e.at   = at;
        sb.push_back(e);
    endtask

    // Expected pulses for lines first sampled at edge e0 from an idle queue
    task automatic expect_from(input int e0, input logic [4:0] pulses);
        int k;
        k = 0;
        if (pulses[3]) push(3, e0 + LAT_SEL);
        if (pulses[4]) push(4, e0 + LAT_SEL);
        for (int c = 0; c < 3; c++) begin
            if (pulses[c]) begin
                push(c, e0 + LAT_COIN + k * (GAP + 1));
                k++;
            end
        end
    endtask

    // Pulse monitor: every observed pulse must match the scoreboard head
    always @(negedge CLK) begin
        logic [4:0] p;
        exp_t e;
        p = {diet, soda, N, D, Q};
        if ({Q, D, N} != 3'b000) begin
            check("coin_onehot", $countones({Q, D, N}), 1);
        end
        for (int k = 0; k < 5; k++) begin
            if (p[k]) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: got %s at cycle %0d, expected none",
                             kname[k], cyc);
                end else begin
                    e = sb.pop_front();
                    check({"pulse_kind_", kname[k]}, k, e.kind);
                    check({"pulse_time_", kname[k]}, cyc, e.at);
                end
            end
        end
    end

    initial begin
        int e0;
        int c;

        vecs[0] = '{"clean_nickel", 5'b00100, 20, 5'b00100};
        vecs[1] = '{"quarter",      5'b00001, 10, 5'b00001};
        vecs[2] = '{"dime",         5'b00010, 10, 5'b00010};
        vecs[3] = '{"soda",         5'b01000, 10, 5'b01000};
        vecs[4] = '{"diet",         5'b10000, 10, 5'b10000};
        vecs[5] = '{"q_glitch3",    5'b00001,  3, 5'b00000};
        vecs[6] = '{"n_glitch_eq",  5'b00100, DB, 5'b00000};
        vecs[7] = '{"n_min_valid",  5'b00100, DB + 1, 5'b00100};
        vecs[8] = '{"sel_conflict", 5'b11000, 10, 5'b01000};
        vecs[9] = '{"three_coins",  5'b00111, 10, 5'b00111};

        // Reset state
        tick(3);
        check("rst_Q", Q, 0);
        check("rst_D", D, 0);
        check("rst_N", N, 0);
        check("rst_soda", soda, 0);
        check("rst_diet", diet, 0);
        check("rst_pending", coin_pending, 0);
        check("rst_overflow", coin_overflow, 0);
        reset = 1'b1;
        tick(2);

        foreach (vecs[i]) begin
            e0 = cyc + 1;
            drive(vecs[i].lines);
            expect_from(e0, vecs[i].pulses);
            tick(vecs[i].hold);
            drive(5'b0);
            tick(30);
            check({"drained_", vecs[i].name}, sb.size(), 0);
            check({"idle_pending_", vecs[i].name}, coin_pending, 0);
        end

        // Diet alone after the conflict case still pulses
        e0 = cyc + 1;
        drive(5'b10000);
        push(4, e0 + LAT_SEL);
        tick(10);
        drive(5'b0);
        tick(30);
        check("drained_diet_after_conflict", sb.size(), 0);

        // Bounce rejection: 3-cycle toggles, then a stable high
        for (int i = 0; i < 5; i++) begin
            drive(5'b00010);
            tick(3);
            drive(5'b0);
            tick(3);
        end
        e0 = cyc + 1;
        drive(5'b00010);
        push(1, e0 + LAT_COIN);
        tick(20);
        drive(5'b0);
        tick(30);
        check("drained_bounce", sb.size(), 0);

        // Backpressure and overflow: four quarters into a depth-3 queue
        accept = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(5'b00001);
            tick(8);
            drive(5'b0);
            tick(8);
        end
        check("bp_q_pend", dut.q_pend, 3);
        check("bp_overflow", coin_overflow, 1);
        check("bp_pending", coin_pending, 1);
        c = cyc;
        accept = 1'b1;
        push(0, c + 1);
        push(0, c + 3);
        push(0, c + 5);
        tick(20);
        check("bp_overflow_sticky", coin_overflow, 1);
        check("bp_pending_done", coin_pending, 0);
        check("drained_bp", sb.size(), 0);

        // Reset mid-operation discards queued dimes and the overflow flag
        accept = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(5'b00010);
            tick(8);
            drive(5'b0);
            tick(8);
        end
        check("mid_d_pend", dut.d_pend, 2);
        check("mid_pending", coin_pending, 1);
        reset = 1'b0;
        tick(1);
        check("mid_rst_Q", Q, 0);
        check("mid_rst_D", D, 0);
        check("mid_rst_N", N, 0);
        check("mid_rst_soda", soda, 0);
        check("mid_rst_diet", diet, 0);
        check("mid_rst_pending", coin_pending, 0);
        check("mid_rst_overflow", coin_overflow, 0);
        reset = 1'b1;
        accept = 1'b1;
        tick(20);
        check("mid_after_pending", coin_pending, 0);
        check("mid_after_overflow", coin_overflow, 0);
        check("mid_after_d_pend", dut.d_pend, 0);
        check("drained_final", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
